// File: rtl/game_datapath.sv
// Board, player and card state for Chicken Cha-Cha-Cha.
// Tiles fill from an LFSR at setup; each card flip is checked against the tile ahead.
module game_datapath #(
    parameter int         TRACK_LEN = 16,
    parameter int         NCARDS    = 12,
    parameter logic [7:0] SEED      = 8'hA5,
    localparam int        PW        = $clog2(TRACK_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        key,
    input  logic [2:0]        M,
    input  logic              WR,
    input  logic              A,
    input  logic              B,
    input  logic [1:0]        N,
    output logic              c,
    output logic              go,
    output logic              win,
    output logic [1:0]        cur_player,
    output logic [4*PW-1:0]   pos_bus,
    output logic [1:0]        tile_ahead,
    output logic [NCARDS-1:0] flipped
);

    localparam logic [PW-1:0] LAST = PW'(TRACK_LEN - 1);
    localparam logic [3:0]    NC   = 4'(NCARDS);

    logic [7:0]             r_lfsr;
    logic [PW-1:0]          r_fill;
    logic                   r_c;
    logic                   r_go;
    logic                   r_win;
    logic [1:0]             r_cur;
    logic [3:0][PW-1:0]     r_pos;
    logic [NCARDS-1:0]      r_flip;
    logic [1:0]             r_tile [TRACK_LEN];

    logic                   w_fb;
    logic                   w_fill;
    logic [PW-1:0]          w_cur_pos;
    logic [PW-1:0]          w_ahead_idx;
    logic [1:0]             w_ahead;
    logic [3:0]             w_kidx;
    logic [NCARDS-1:0]      w_kmask;
    logic                   w_seen;
    logic                   w_match;
    logic [2:0]             w_np;
    logic [2:0]             w_next_cur;
    logic                   w_unused;

    // Prompt/display strobes have no datapath effect
    assign w_unused = ^{A, B};

    assign w_fb        = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_fill      = !rst && (M == 3'b000) && WR && !r_c;

    assign w_cur_pos   = r_pos[r_cur];
    assign w_ahead_idx = (w_cur_pos == LAST) ? '0 : w_cur_pos + PW'(1);
    assign w_ahead     = r_tile[w_ahead_idx];

    assign w_kidx      = key - 4'd1;
    assign w_kmask     = {{(NCARDS-1){1'b0}}, 1'b1} << w_kidx;
    assign w_seen      = |(r_flip & w_kmask);
    assign w_match     = !w_seen && (w_kidx[1:0] == w_ahead);

    // N==1 is illegal and behaves as a two-player game
    assign w_np        = (N == 2'd0) ? 3'd4 :
                         (N == 2'd1) ? 3'd2 : {1'b0, N};
    assign w_next_cur  = ({1'b0, r_cur} + 3'd1) % w_np;

    // Track tiles carry no reset; setup always rewrites every entry
    always_ff @(posedge clk) begin
        if (w_fill)
            r_tile[r_fill] <= r_lfsr[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
            r_fill <= '0;
            r_c    <= 1'b0;
            r_go   <= 1'b0;
            r_win  <= 1'b0;
            r_cur  <= 2'd0;
            r_pos  <= '0;
            r_flip <= '0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
            if (w_fill) begin
                r_fill <= r_fill + PW'(1);
                if (r_fill == LAST)
                    r_c <= 1'b1;
            end
            case (M)
                3'b011: begin
                    if (key != 4'd0) begin
                        if (key <= NC) begin
                            r_go   <= w_match;
                            r_flip <= r_flip | w_kmask;
                        end else begin
                            r_go   <= 1'b0;
                        end
                    end
                end
                3'b100: begin
                    if (r_go) begin
                        r_pos[r_cur] <= w_ahead_idx;
                        r_win        <= (w_ahead_idx == LAST);
                    end
                end
                3'b101: begin
                    r_cur  <= w_next_cur[1:0];
                    r_flip <= '0;
                    r_go   <= 1'b0;
                end
                3'b110: begin
                    r_go <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign c          = r_c;
    assign go         = r_go;
    assign win        = r_win;
    assign cur_player = r_cur;
    assign pos_bus    = r_pos;
    assign tile_ahead = w_ahead;
    assign flipped    = r_flip;

endmodule

// File: tb/tb_game_datapath.sv
// Randomized game play against a behavioural board model.
// Covers setup fill, card evaluation, moves, turn rotation, win freeze and reset.
module tb_game_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [2:0]  M;
    logic        WR;
    logic        A;
    logic        B;
    logic [1:0]  N;
    logic        c;
    logic        go;
    logic        win;
    logic [1:0]  cur_player;
    logic [15:0] pos_bus;
    logic [1:0]  tile_ahead;
    logic [11:0] flipped;

    always #5 clk = ~clk;

    game_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .M          (M),
        .WR         (WR),
        .A          (A),
        .B          (B),
        .N          (N),
        .c          (c),
        .go         (go),
        .win        (win),
        .cur_player (cur_player),
        .pos_bus    (pos_bus),
        .tile_ahead (tile_ahead),
        .flipped    (flipped)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model of the board
    bit [7:0] m_lfsr;
    int       m_fill;
    int       m_cur;
    bit       m_c;
    bit       m_go;
    bit       m_win;
    bit       m_tv;
    int       m_pos  [4];
    bit       m_flip [13];
    int       m_tile [16];

    function automatic bit [7:0] lfsr_next(bit [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic int ahead();
        return m_tile[(m_pos[m_cur] + 1) % 16];
    endfunction

    function automatic void model_reset();
        m_lfsr = 8'hA5;
        m_fill = 0;
        m_cur  = 0;
        m_c    = 0;
        m_go   = 0;
        m_win  = 0;
        for (int p = 0; p < 4; p++) m_pos[p] = 0;
        for (int i = 0; i < 13; i++) m_flip[i] = 0;
    endfunction

    function automatic void model(bit r, bit [2:0] m, bit wr,
                                  bit [1:0] n, bit [3:0] k);
        int a;
        int ki;
        int np;
        if (r) begin
            model_reset();
            return;
        end
        a  = ahead();
        ki = int'(k);
        if (m == 3'd0 && wr && !m_c) begin
            m_tile[m_fill] = int'(m_lfsr[1:0]);
            if (m_fill == 15) begin
                m_c  = 1;
                m_tv = 1;
            end
            m_fill++;
        end
        m_lfsr = lfsr_next(m_lfsr);
        case (m)
            3'd3: if (ki != 0) begin
                if (ki <= 12) begin
                    m_go = !m_flip[ki] && ((ki - 1) % 4 == a);
                    m_flip[ki] = 1;
                end else begin
                    m_go = 0;
                end
            end
            3'd4: if (m_go) begin
                m_pos[m_cur] = (m_pos[m_cur] + 1) % 16;
                m_win = (m_pos[m_cur] == 15);
            end
            3'd5: begin
                np = (n == 0) ? 4 : (n == 1) ? 2 : int'(n);
                m_cur = (m_cur + 1) % np;
                for (int i = 0; i < 13; i++) m_flip[i] = 0;
                m_go = 0;
            end
            3'd6: m_go = 0;
            default: ;
        endcase
    endfunction

    task automatic compare_all();
        logic [15:0] ep;
        logic [11:0] ef;
        for (int p = 0; p < 4; p++) ep[p*4 +: 4] = 4'(m_pos[p]);
        for (int i = 1; i <= 12; i++) ef[i-1] = m_flip[i];
        chk("c", 64'(c), 64'(m_c));
        chk("go", 64'(go), 64'(m_go));
        chk("win", 64'(win), 64'(m_win));
        chk("cur_player", 64'(cur_player), 64'(m_cur));
        chk("pos_bus", 64'(pos_bus), 64'(ep));
        chk("flipped", 64'(flipped), 64'(ef));
        if (m_tv)
            chk("tile_ahead", 64'(tile_ahead), 64'(ahead()));
    endtask

    task automatic step(input logic r, input logic [2:0] m, input logic wr,
                        input logic [1:0] n, input logic [3:0] k);
        rst = r;
        M   = m;
        WR  = wr;
        N   = n;
        key = k;
        A   = 1'($urandom);
        B   = 1'($urandom);
        @(posedge clk);
        #1;
        model(r, m, wr, n, k);
        compare_all();
    endtask

    function automatic int pick_match();
        int a;
        int off;
        int kk;
        a   = ahead();
        off = int'($urandom_range(0, 2));
        for (int j = 0; j < 3; j++) begin
            kk = a + 1 + 4 * ((j + off) % 3);
            if (!m_flip[kk]) return kk;
        end
        return 0;
    endfunction

    function automatic int pick_miss();
        int a;
        a = ahead();
        for (int i = 1; i <= 12; i++)
            if (!m_flip[i] && ((i - 1) % 4 != a)) return i;
        return 0;
    endfunction

    task automatic play(input bit rnd_n, output bit won);
        logic [1:0] n;
        int k;
        won = 0;
        n = rnd_n ? 2'($urandom) : 2'b10;
        for (int t = 0; t < 300 && !won; t++) begin
            if (rnd_n && $urandom_range(0, 9) == 0) n = 2'($urandom);
            step(0, 3'b001, 1'($urandom), n, 4'($urandom));
            step(0, 3'b010, 1'b0, n, 4'($urandom));
            for (int e = 0; e < 14; e++) begin
                k = 0;
                if ($urandom_range(0, 3) != 0) k = pick_match();
                if (k == 0) k = int'($urandom_range(0, 15));
                step(0, 3'b011, 1'b0, n, 4'(k));
                step(0, 3'b100, 1'b0, n, 4'($urandom));
                if (m_win) begin
                    won = 1;
                    break;
                end
                if (m_go) begin
                    step(0, 3'b110, 1'b0, n, 4'($urandom));
                end else begin
                    step(0, 3'b101, 1'b0, n, 4'($urandom));
                    break;
                end
            end
        end
        if (won) begin
            chk("win_set", 64'(win), 64'd1);
            step(0, 3'b110, 1'b0, n, 4'($urandom));
            for (int i = 0; i < 10; i++)
                step(0, 3'b111, 1'($urandom), 2'($urandom), 4'($urandom));
            chk("win_hold", 64'(win), 64'd1);
        end
    endtask

    initial begin
        int k;
        int k2;
        int k3;
        bit won;
        logic [11:0] msk;

        m_tv = 0;
        for (int i = 0; i < 16; i++) m_tile[i] = 0;
        model_reset();

        step(1, 3'b000, 1'b0, 2'b00, 4'd0);
        step(1, 3'b000, 1'b0, 2'b00, 4'd0);
        chk("rst_c", 64'(c), 64'd0);
        chk("rst_pos", 64'(pos_bus), 64'd0);
        chk("rst_flipped", 64'(flipped), 64'd0);

        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("setup_c_before_last", 64'(c), 64'd0);
            step(0, 3'b000, 1'b1, 2'b00, 4'd0);
        end
        chk("setup_c_done", 64'(c), 64'd1);

        k = pick_match();
        step(0, 3'b011, 1'b0, 2'b00, 4'(k));
        chk("t2_go", 64'(go), 64'd1);
        step(0, 3'b100, 1'b0, 2'b00, 4'd0);
        msk = 12'd1 << (k - 1);
        chk("t2_pos0", 64'(pos_bus[3:0]), 64'd1);
        chk("t2_win", 64'(win), 64'd0);
        chk("t2_mask", 64'(flipped), 64'(msk));
        step(0, 3'b110, 1'b0, 2'b00, 4'd0);
        chk("t2_go_clr", 64'(go), 64'd0);

        k2 = pick_match();
        step(0, 3'b011, 1'b0, 2'b00, 4'(k2));
        chk("t4_go_k2", 64'(go), 64'd1);
        step(0, 3'b011, 1'b0, 2'b00, 4'd13);
        msk = msk | (12'd1 << (k2 - 1));
        chk("t4_key13_go", 64'(go), 64'd0);
        chk("t4_key13_mask", 64'(flipped), 64'(msk));
        k3 = pick_match();
        step(0, 3'b011, 1'b0, 2'b00, 4'(k3));
        chk("t4_go_k3", 64'(go), 64'd1);
        step(0, 3'b011, 1'b0, 2'b00, 4'(k3));
        chk("t4_reflip", 64'(go), 64'd0);
        step(0, 3'b100, 1'b0, 2'b00, 4'd0);
        chk("t4_no_move", 64'(pos_bus[3:0]), 64'd1);

        k = pick_miss();
        step(0, 3'b011, 1'b0, 2'b00, 4'(k));
        chk("t3_go", 64'(go), 64'd0);
        step(0, 3'b100, 1'b0, 2'b00, 4'd0);
        step(0, 3'b101, 1'b0, 2'b00, 4'd0);
        chk("t3_cur", 64'(cur_player), 64'd1);
        chk("t3_mask", 64'(flipped), 64'd0);

        play(1'b0, won);
        chk("win_reached_1", 64'(won), 64'd1);

        step(1, 3'b011, 1'b1, 2'b00, 4'd5);
        chk("mid_rst_c", 64'(c), 64'd0);
        chk("mid_rst_win", 64'(win), 64'd0);
        chk("mid_rst_cur", 64'(cur_player), 64'd0);
        chk("mid_rst_pos", 64'(pos_bus), 64'd0);

        for (int i = 0; i < 200 && !m_c; i++)
            step(0, 3'b000, 1'($urandom_range(0, 2) != 0), 2'b00, 4'($urandom));
        chk("resetup_c", 64'(c), 64'd1);

        for (int i = 0; i < 4; i++) begin
            step(0, 3'b101, 1'b0, 2'b00, 4'd0);
            chk("n4_cur", 64'(cur_player), 64'((i + 1) % 4));
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 3'b101, 1'b0, 2'b10, 4'd0);
            chk("n2_cur", 64'(cur_player), 64'((i + 1) % 2));
        end

        play(1'b1, won);
        chk("win_reached_2", 64'(won), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
